rob_walk_sequencer: RTL and testbench

Sequences the post-redirect rollback walk that restores speculative rename state (busy table ready bits, rename map) after a branch/exception redirect. On a redirect it captures the squash boundary and the ROB tail, reads squashed ROB entries newest-first up to `WALK_WIDTH` per cycle, and drives the commit-walk lanes consumed by the busy table and rename logic. While it runs, it holds dispatch stalled.

---
 rtl/rob_walk_sequencer_if.sv | 47 ++++
 rtl/rob_walk_sequencer.sv | 149 ++++++++++++++
 tb/tb_rob_walk_sequencer.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/rob_walk_sequencer_if.sv
// Rollback-walk sequencer bus: redirect request, ROB read port and walk lanes.
// Optional statistics outputs exist only when WALK_SEQ_STAT_EN is defined.
interface rob_walk_sequencer_if #(
  parameter int unsigned ROB_SIZE   = 64,
  parameter int unsigned WALK_WIDTH = 4,
  parameter int unsigned PREG_WIDTH = 7
);
  localparam int unsigned IW = $clog2(ROB_SIZE) + 1;

  logic                                  redirect_valid;
  logic [IW-1:0]                         redirect_idx;
  logic [IW-1:0]                         rob_tail;
  logic [WALK_WIDTH-1:0][IW-2:0]         rob_rd_idx;
  logic [WALK_WIDTH-1:0]                 rob_rd_we;
  logic [WALK_WIDTH-1:0][PREG_WIDTH-1:0] rob_rd_prd;
  logic                                  walk;
  logic [WALK_WIDTH-1:0]                 walk_en;
  logic [WALK_WIDTH-1:0]                 walk_we;
  logic [WALK_WIDTH-1:0][PREG_WIDTH-1:0] walk_prd;
  logic                                  walk_busy;
  logic                                  walk_done;
  logic                                  stall_dispatch;
`ifdef WALK_SEQ_STAT_EN
  logic [31:0]                           stat_walk_cycles;
  logic [31:0]                           stat_walks;
`endif

  // Sequencer side
  modport master (
    input  redirect_valid, redirect_idx, rob_tail, rob_rd_we, rob_rd_prd,
    output rob_rd_idx, walk, walk_en, walk_we, walk_prd, walk_busy, walk_done,
    output stall_dispatch
`ifdef WALK_SEQ_STAT_EN
    , output stat_walk_cycles, stat_walks
`endif
  );

  // Redirect source / ROB / rename side
  modport slave (
    output redirect_valid, redirect_idx, rob_tail, rob_rd_we, rob_rd_prd,
    input  rob_rd_idx, walk, walk_en, walk_we, walk_prd, walk_busy, walk_done,
    input  stall_dispatch
`ifdef WALK_SEQ_STAT_EN
    , input stat_walk_cycles, stat_walks
`endif
  );
endinterface

// File: rtl/rob_walk_sequencer.sv
// Post-redirect rollback walk: reads squashed ROB entries newest-first,
// up to WALK_WIDTH per cycle, and drives the walk lanes for busy table and
// rename restore. Dispatch is stalled while a redirect or walk is pending.
// Define WALK_SEQ_STAT_EN to add saturating walk-cycle / walk-count counters.
module rob_walk_sequencer #(
  parameter int unsigned ROB_SIZE   = 64,
  parameter int unsigned WALK_WIDTH = 4,
  parameter int unsigned PREG_WIDTH = 7
) (
  input  logic                    clk,
  input  logic                    rst,
  rob_walk_sequencer_if.master    bus
);
  localparam int unsigned IW = $clog2(ROB_SIZE) + 1;
  localparam int unsigned LW = IW - 1;

  typedef enum logic [1:0] {S_IDLE, S_WALK, S_DONE} state_t;

  state_t        r_state, w_state_nxt;
  logic [IW-1:0] r_ptr, r_stop;
  logic [IW-1:0] w_ptr_nxt, w_stop_nxt;
  logic [IW-1:0] w_remaining, w_n, w_new_stop, w_cur_redirect, w_rem_after;
  logic          w_older, w_walking, w_done;

  logic [WALK_WIDTH-1:0]                 w_lane_en;
  logic [WALK_WIDTH-1:0][LW-1:0]         w_lane_idx;
  logic [WALK_WIDTH-1:0]                 w_lane_we;
  logic [WALK_WIDTH-1:0][PREG_WIDTH-1:0] w_lane_prd;
  logic [LW-1:0]                         w_lane_addr;

  assign w_remaining    = r_ptr - r_stop;
  assign w_n            = (w_remaining > IW'(WALK_WIDTH)) ? IW'(WALK_WIDTH) : w_remaining;
  assign w_new_stop     = bus.redirect_idx + IW'(1);
  assign w_cur_redirect = r_stop - IW'(1);

  // Age compare of incoming redirect against the captured one (wrap-bit aware)
  always_comb begin
    w_older = 1'b0;
    if (bus.redirect_idx[IW-1] == w_cur_redirect[IW-1])
      w_older = bus.redirect_idx[LW-1:0] < w_cur_redirect[LW-1:0];
    else
      w_older = bus.redirect_idx[LW-1:0] > w_cur_redirect[LW-1:0];
  end

  // State, walk pointer and stop boundary registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_ptr   <= '0;
      r_stop  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_stop  <= w_stop_nxt;
    end
  end

  // Next-state logic; an older redirect narrows the stop boundary while the
  // beat issued this cycle still completes against the old boundary
  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_stop_nxt  = r_stop;
    w_rem_after = '0;
    w_walking   = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.redirect_valid) begin
          w_ptr_nxt   = bus.rob_tail;
          w_stop_nxt  = w_new_stop;
          w_state_nxt = (bus.rob_tail != w_new_stop) ? S_WALK : S_DONE;
        end
      end
      S_WALK: begin
        w_walking   = 1'b1;
        w_ptr_nxt   = r_ptr - w_n;
        w_state_nxt = (w_remaining <= IW'(WALK_WIDTH)) ? S_DONE : S_WALK;
        if (bus.redirect_valid && w_older) begin
          w_stop_nxt  = w_new_stop;
          w_rem_after = w_ptr_nxt - w_new_stop;
          w_state_nxt = (w_rem_after == '0) ? S_DONE : S_WALK;
        end
      end
      S_DONE: begin
        w_done      = 1'b1;
        w_state_nxt = S_IDLE;
        if (bus.redirect_valid && w_older) begin
          w_stop_nxt  = w_new_stop;
          w_rem_after = r_ptr - w_new_stop;
          if (w_rem_after != '0) begin
            w_state_nxt = S_WALK;
            w_done      = 1'b0;
          end else begin
            w_state_nxt = S_DONE;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Walk lanes: lane k reads entry ptr-1-k; idle lanes drive zero
  always_comb begin
    w_lane_en   = '0;
    w_lane_idx  = '0;
    w_lane_we   = '0;
    w_lane_prd  = '0;
    w_lane_addr = '0;
    for (int unsigned k = 0; k < WALK_WIDTH; k++) begin
      w_lane_addr  = r_ptr[LW-1:0] - LW'(k + 1);
      w_lane_en[k] = w_walking && (IW'(k) < w_n);
      if (w_lane_en[k]) begin
        w_lane_idx[k] = w_lane_addr;
        w_lane_we[k]  = bus.rob_rd_we[k];
        w_lane_prd[k] = bus.rob_rd_prd[k];
      end
    end
  end

  assign bus.rob_rd_idx     = w_lane_idx;
  assign bus.walk           = w_walking;
  assign bus.walk_en        = w_lane_en;
  assign bus.walk_we        = w_lane_we;
  assign bus.walk_prd       = w_lane_prd;
  assign bus.walk_busy      = (r_state != S_IDLE);
  assign bus.walk_done      = w_done;
  assign bus.stall_dispatch = bus.redirect_valid | (r_state != S_IDLE);

`ifdef WALK_SEQ_STAT_EN
  logic [31:0] r_stat_walk_cycles, r_stat_walks;

  // Saturating counters of walk beats and completed walks
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stat_walk_cycles <= '0;
      r_stat_walks       <= '0;
    end else begin
      if (w_walking && (r_stat_walk_cycles != '1))
        r_stat_walk_cycles <= r_stat_walk_cycles + 32'd1;
      if (w_done && (r_stat_walks != '1))
        r_stat_walks <= r_stat_walks + 32'd1;
    end
  end

  assign bus.stat_walk_cycles = r_stat_walk_cycles;
  assign bus.stat_walks       = r_stat_walks;
`endif
endmodule

// File: tb/tb_rob_walk_sequencer.sv
// Directed bench for rob_walk_sequencer (ROB_SIZE=64, WALK_WIDTH=4).
// ROB model: entry i writes rd when i is even, and holds prd = 64 + i.
module tb_rob_walk_sequencer;
  logic clk = 1'b0;
  logic rst;
  int   n_eval = 0;
  int   n_fail = 0;

  rob_walk_sequencer_if #(.ROB_SIZE(64), .WALK_WIDTH(4), .PREG_WIDTH(7)) bus ();

  rob_walk_sequencer #(.ROB_SIZE(64), .WALK_WIDTH(4), .PREG_WIDTH(7)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      bus.rob_rd_we[k]  = ~bus.rob_rd_idx[k][0];
      bus.rob_rd_prd[k] = {1'b1, bus.rob_rd_idx[k]};
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_eval++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic redir(input logic [6:0] idx, input logic [6:0] tail);
    bus.redirect_valid = 1'b1;
    bus.redirect_idx   = idx;
    bus.rob_tail       = tail;
  endtask

  // Checks every walk output for one cycle given hand-listed lane indices
  task automatic beat(input string tag, input logic [3:0] en,
                      input int unsigned i0, input int unsigned i1,
                      input int unsigned i2, input int unsigned i3,
                      input logic done, input logic busy);
    logic [3:0][5:0] eidx;
    logic [3:0]      ewe;
    logic [3:0][6:0] eprd;
    int unsigned     ix [4];
    ix = '{i0, i1, i2, i3};
    for (int k = 0; k < 4; k++) begin
      eidx[k] = '0; ewe[k] = 1'b0; eprd[k] = '0;
      if (en[k]) begin
        eidx[k] = 6'(ix[k]);
        ewe[k]  = ~eidx[k][0];
        eprd[k] = {1'b1, eidx[k]};
      end
    end
    chk({tag, "_walk"},  64'(bus.walk),           64'(en != 4'b0));
    chk({tag, "_en"},    64'(bus.walk_en),        64'(en));
    chk({tag, "_idx"},   64'(bus.rob_rd_idx),     64'(eidx));
    chk({tag, "_we"},    64'(bus.walk_we),        64'(ewe));
    chk({tag, "_prd"},   64'(bus.walk_prd),       64'(eprd));
    chk({tag, "_done"},  64'(bus.walk_done),      64'(done));
    chk({tag, "_busy"},  64'(bus.walk_busy),      64'(busy));
    chk({tag, "_stall"}, 64'(bus.stall_dispatch), 64'(busy | bus.redirect_valid));
  endtask

  initial begin
    rst = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_idx   = '0;
    bus.rob_tail       = '0;
    #2;
    beat("rst", 4'b0000, 0, 0, 0, 0, 1'b0, 1'b0);
    redir(7'd9, 7'd20);
    #1;
    chk("rst_stall_follows", 64'(bus.stall_dispatch), 64'(1));
    chk("rst_no_walk",       64'(bus.walk),           64'(0));
    bus.redirect_valid = 1'b0;
    cyc();
    rst = 1'b0;
    cyc();
    beat("idle0", 4'b0000, 0, 0, 0, 0, 1'b0, 1'b0);

    // Basic walk: 9 entries, 14 down to 6
    redir(7'd5, 7'd15);
    #1;
    chk("b_req_stall", 64'(bus.stall_dispatch), 64'(1));
    chk("b_req_walk",  64'(bus.walk),           64'(0));
    cyc(); bus.redirect_valid = 1'b0;
    beat("b1", 4'b1111, 14, 13, 12, 11, 1'b0, 1'b1);
    cyc(); beat("b2", 4'b1111, 10, 9, 8, 7, 1'b0, 1'b1);
    cyc(); beat("b3", 4'b0001, 6, 0, 0, 0, 1'b0, 1'b1);
    cyc(); beat("bdone", 4'b0000, 0, 0, 0, 0, 1'b1, 1'b1);
    cyc(); beat("bidle", 4'b0000, 0, 0, 0, 0, 1'b0, 1'b0);

    // Empty walk
    redir(7'd20, 7'd21);
    cyc(); bus.redirect_valid = 1'b0;
    beat("edone", 4'b0000, 0, 0, 0, 0, 1'b1, 1'b1);
    cyc(); beat("eidle", 4'b0000, 0, 0, 0, 0, 1'b0, 1'b0);

    // Wrap: redirect {0,62}, tail {1,2}
    redir(7'd62, 7'd66);
    cyc(); bus.redirect_valid = 1'b0;
    beat("w1", 4'b0111, 1, 0, 63, 0, 1'b0, 1'b1);
    cyc(); beat("wdone", 4'b0000, 0, 0, 0, 0, 1'b1, 1'b1);
    cyc(); beat("widle", 4'b0000, 0, 0, 0, 0, 1'b0, 1'b0);

    // Older redirect during first beat narrows the walk to stop at 23
    redir(7'd30, 7'd40);
    cyc(); bus.redirect_valid = 1'b0;
    beat("o1", 4'b1111, 39, 38, 37, 36, 1'b0, 1'b1);
    redir(7'd22, 7'd40);
    #1;
    beat("o1r", 4'b1111, 39, 38, 37, 36, 1'b0, 1'b1);
    cyc(); bus.redirect_valid = 1'b0;
    beat("o2", 4'b1111, 35, 34, 33, 32, 1'b0, 1'b1);
    cyc(); beat("o3", 4'b1111, 31, 30, 29, 28, 1'b0, 1'b1);
    cyc(); beat("o4", 4'b1111, 27, 26, 25, 24, 1'b0, 1'b1);
    cyc(); beat("o5", 4'b0001, 23, 0, 0, 0, 1'b0, 1'b1);
    cyc(); beat("odone", 4'b0000, 0, 0, 0, 0, 1'b1, 1'b1);
    cyc(); beat("oidle", 4'b0000, 0, 0, 0, 0, 1'b0, 1'b0);

    // Younger redirect is ignored
    redir(7'd30, 7'd40);
    cyc(); bus.redirect_valid = 1'b0;
    beat("y1", 4'b1111, 39, 38, 37, 36, 1'b0, 1'b1);
    redir(7'd35, 7'd40);
    #1;
    beat("y1r", 4'b1111, 39, 38, 37, 36, 1'b0, 1'b1);
    cyc(); bus.redirect_valid = 1'b0;
    beat("y2", 4'b1111, 35, 34, 33, 32, 1'b0, 1'b1);
    cyc(); beat("y3", 4'b0001, 31, 0, 0, 0, 1'b0, 1'b1);
    cyc(); beat("ydone", 4'b0000, 0, 0, 0, 0, 1'b1, 1'b1);
    cyc(); beat("yidle", 4'b0000, 0, 0, 0, 0, 1'b0, 1'b0);

    // Reset during the second beat
    redir(7'd5, 7'd15);
    cyc(); bus.redirect_valid = 1'b0;
    beat("r1", 4'b1111, 14, 13, 12, 11, 1'b0, 1'b1);
    cyc(); beat("r2", 4'b1111, 10, 9, 8, 7, 1'b0, 1'b1);
`ifdef WALK_SEQ_STAT_EN
    chk("stat_walks_pre",  64'(bus.stat_walks),       64'(5));
    chk("stat_cycles_pre", 64'(bus.stat_walk_cycles), 64'(13));
`endif
    rst = 1'b1;
    #1;
    beat("rmid", 4'b0000, 0, 0, 0, 0, 1'b0, 1'b0);
`ifdef WALK_SEQ_STAT_EN
    chk("stat_walks_rst",  64'(bus.stat_walks),       64'(0));
    chk("stat_cycles_rst", 64'(bus.stat_walk_cycles), 64'(0));
`endif
    cyc(); beat("rhold", 4'b0000, 0, 0, 0, 0, 1'b0, 1'b0);
    rst = 1'b0;
    cyc(); beat("rafter", 4'b0000, 0, 0, 0, 0, 1'b0, 1'b0);
    cyc(); beat("rafter2", 4'b0000, 0, 0, 0, 0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_eval, n_fail);
    $finish;
  end
endmodule
